// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate controller for a 16-set, 2-way data cache.
// Sequences lookup, dirty-victim writeback and line refill over a req/ack memory port.
module dcache_ctrl #(
   parameter int TAG_W  = 23,
   parameter int IDX_W  = 4,
   parameter int LINE_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   output logic              sram_enable_o,
   output logic              sram_write_o,
   output logic [IDX_W-1:0]  sram_addr_o,
   output logic [TAG_W+1:0]  sram_tag_o,
   output logic [LINE_W-1:0] sram_data_o,
   input  logic [TAG_W+1:0]  sram_tag_i,
   input  logic [LINE_W-1:0] sram_data_i,
   input  logic              sram_hit_i,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
);

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      REFILL,
      REFILL_DONE
   } state_t;

   state_t state_q, state_d;

   logic [TAG_W-1:0]  cpu_tag;
   logic [IDX_W-1:0]  cpu_idx;
   logic [2:0]        word_off;
   logic [31:0]       cpu_line_addr;
   logic [31:0]       hit_word;
   logic [LINE_W-1:0] store_line;
   logic              victim_dirty;

   logic [31:0]       data_q;
   logic [31:0]       hit_cnt_q, miss_cnt_q;
   logic              mem_enable_q, mem_write_q;
   logic [31:0]       mem_addr_q;
   logic [LINE_W-1:0] mem_data_q;

   logic              count_hit, count_miss, load_hit;
   logic              unused_addr_bits;

   assign cpu_tag          = cpu_addr_i[31 -: TAG_W];
   assign cpu_idx          = cpu_addr_i[5 +: IDX_W];
   assign word_off         = cpu_addr_i[4:2];
   assign cpu_line_addr    = {cpu_addr_i[31:5], 5'b0};
   assign hit_word         = sram_data_i[{word_off, 5'b0} +: 32];
   assign victim_dirty     = sram_tag_i[TAG_W+1] & sram_tag_i[TAG_W];
   assign unused_addr_bits = &{1'b0, cpu_addr_i[1:0]};

   assign sram_addr_o  = cpu_idx;
   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;
   assign hit_cnt_o    = hit_cnt_q;
   assign miss_cnt_o   = miss_cnt_q;

   // Load hits bypass the register so data is visible in the same cycle
   assign cpu_data_o = load_hit ? hit_word : data_q;

   // The hit line with the addressed word merged in for store hits
   always_comb begin
      store_line = sram_data_i;
      store_line[{word_off, 5'b0} +: 32] = cpu_data_i;
   end

   // Next-state logic plus all SRAM-side strobes and CPU stall
   always_comb begin
      state_d       = state_q;
      cpu_stall_o   = 1'b1;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      sram_tag_o    = {1'b1, 1'b0, cpu_tag};
      sram_data_o   = store_line;
      count_hit     = 1'b0;
      count_miss    = 1'b0;
      load_hit      = 1'b0;
      case (state_q)
         IDLE: begin
            cpu_stall_o = 1'b0;
            if (cpu_req_i) begin
               sram_enable_o = 1'b1;
               if (sram_hit_i) begin
                  count_hit = 1'b1;
                  if (cpu_we_i) begin
                     sram_write_o = 1'b1;
                     sram_tag_o   = {1'b1, 1'b1, cpu_tag};
                  end else begin
                     load_hit = 1'b1;
                  end
               end else begin
                  cpu_stall_o = 1'b1;
                  count_miss  = 1'b1;
                  state_d     = MISS;
               end
            end
         end
         MISS: begin
            sram_enable_o = 1'b1;
            state_d       = victim_dirty ? WRITEBACK : REFILL;
         end
         WRITEBACK: begin
            if (mem_ack_i) state_d = REFILL;
         end
         REFILL: begin
            if (mem_enable_q && mem_ack_i) begin
               sram_enable_o = 1'b1;
               sram_write_o  = 1'b1;
               sram_data_o   = mem_data_i;
               sram_tag_o    = {1'b1, 1'b0, cpu_tag};
               state_d       = REFILL_DONE;
            end
         end
         REFILL_DONE: state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Memory request registers; the victim tag and line are captured here during MISS
   // and the read is reissued one cycle after the writeback is acknowledged
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
      end else begin
         case (state_q)
            MISS: begin
               mem_enable_q <= 1'b1;
               if (victim_dirty) begin
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= {sram_tag_i[TAG_W-1:0], cpu_idx, 5'b0};
                  mem_data_q  <= sram_data_i;
               end else begin
                  mem_write_q <= 1'b0;
                  mem_addr_q  <= cpu_line_addr;
               end
            end
            WRITEBACK: begin
               if (mem_ack_i) begin
                  mem_enable_q <= 1'b0;
                  mem_write_q  <= 1'b0;
                  mem_addr_q   <= cpu_line_addr;
               end
            end
            REFILL: begin
               if (!mem_enable_q)  mem_enable_q <= 1'b1;
               else if (mem_ack_i) mem_enable_q <= 1'b0;
            end
            default: mem_enable_q <= 1'b0;
         endcase
      end
   end

   // Saturating performance counters and the held load-data register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (load_hit) data_q <= hit_word;
         if (count_hit && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (count_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural 2-way SRAM and memory, plus a line-level
// reference model of residency, dirtiness and CPU-visible data.
module tb_dcache_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         cpu_req_i, cpu_we_i;
   logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
   logic         cpu_stall_o;
   logic         sram_enable_o, sram_write_o;
   logic [3:0]   sram_addr_o;
   logic [24:0]  sram_tag_o, sram_tag_i;
   logic [255:0] sram_data_o, sram_data_i;
   logic         sram_hit_i;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o, mem_data_i;
   logic         mem_ack_i;
   logic [31:0]  hit_cnt_o, miss_cnt_o;

   int total = 0;
   int bad   = 0;

   dcache_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
      .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_addr_o(sram_addr_o),
      .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o), .sram_tag_i(sram_tag_i),
      .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] default_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // ---------------- behavioural 2-way SRAM, FIFO replacement ----------------
   logic [24:0]  tag_mem  [16][2] = '{default: '0};
   logic [255:0] data_mem [16][2] = '{default: '0};
   logic         vptr     [16]    = '{default: 1'b0};
   logic         m_hit0, m_hit1;

   always_comb begin
      m_hit0 = tag_mem[sram_addr_o][0][24] && (tag_mem[sram_addr_o][0][22:0] == cpu_addr_i[31:9]);
      m_hit1 = tag_mem[sram_addr_o][1][24] && (tag_mem[sram_addr_o][1][22:0] == cpu_addr_i[31:9]);
      sram_hit_i = m_hit0 | m_hit1;
      if (m_hit0) begin
         sram_tag_i  = tag_mem[sram_addr_o][0];
         sram_data_i = data_mem[sram_addr_o][0];
      end else if (m_hit1) begin
         sram_tag_i  = tag_mem[sram_addr_o][1];
         sram_data_i = data_mem[sram_addr_o][1];
      end else begin
         sram_tag_i  = tag_mem[sram_addr_o][vptr[sram_addr_o]];
         sram_data_i = data_mem[sram_addr_o][vptr[sram_addr_o]];
      end
   end

   always @(posedge clk_i) begin
      if (sram_enable_o && sram_write_o) begin
         if (m_hit0) begin
            tag_mem[sram_addr_o][0]  <= sram_tag_o;
            data_mem[sram_addr_o][0] <= sram_data_o;
         end else if (m_hit1) begin
            tag_mem[sram_addr_o][1]  <= sram_tag_o;
            data_mem[sram_addr_o][1] <= sram_data_o;
         end else begin
            tag_mem[sram_addr_o][vptr[sram_addr_o]]  <= sram_tag_o;
            data_mem[sram_addr_o][vptr[sram_addr_o]] <= sram_data_o;
            vptr[sram_addr_o] <= ~vptr[sram_addr_o];
         end
      end
   end

   // ---------------- backing memory with programmable ack delay ----------------
   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] data;
   } txn_t;

   logic [255:0] mem_model [logic [31:0]];
   txn_t         txn_log [$];
   int           ack_delay = 3;
   logic         resp_ack  = 1'b0;
   logic         extra_ack = 1'b0;
   logic [255:0] resp_data = '0;

   assign mem_ack_i  = resp_ack | extra_ack;
   assign mem_data_i = resp_data;

   function automatic logic [255:0] default_line(input logic [31:0] la);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = default_word(la + 32'(i * 4));
      return l;
   endfunction

   initial begin
      int           wait_cnt;
      logic         stable;
      logic         cap_wr;
      logic [31:0]  cap_addr;
      logic [255:0] cap_data;
      txn_t         t;
      wait_cnt = 0;
      stable   = 1'b1;
      cap_wr   = 1'b0;
      cap_addr = '0;
      cap_data = '0;
      mem_model[32'h40] = {192'd0, 32'd7, 32'd6};
      forever begin
         @(negedge clk_i);
         resp_ack = 1'b0;
         if (rst_i || !mem_enable_o) begin
            wait_cnt = 0;
         end else begin
            if (wait_cnt == 0) begin
               cap_wr = mem_write_o; cap_addr = mem_addr_o; cap_data = mem_data_o;
               stable = 1'b1;
            end else if (cap_wr !== mem_write_o || cap_addr !== mem_addr_o ||
                         (cap_wr && cap_data !== mem_data_o) || cpu_stall_o !== 1'b1) begin
               stable = 1'b0;
            end
            wait_cnt++;
            if (wait_cnt >= ack_delay) begin
               checkOutput("mem_req_hold", 256'(stable), 256'(1));
               t.wr = mem_write_o; t.addr = mem_addr_o; t.data = mem_data_o;
               txn_log.push_back(t);
               if (mem_write_o)                  mem_model[mem_addr_o] = mem_data_o;
               else if (mem_model.exists(mem_addr_o)) resp_data = mem_model[mem_addr_o];
               else                              resp_data = default_line(mem_addr_o);
               resp_ack = 1'b1;
               wait_cnt = 0;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [22:0] tag;
      logic        dirty;
   } line_t;

   line_t       resident [16][$];
   logic [31:0] ref_words [logic [31:0]];
   logic [31:0] ref_hit  = '0;
   logic [31:0] ref_miss = '0;

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      return ref_words.exists(a) ? ref_words[a] : default_word(a);
   endfunction

   function automatic logic [255:0] ref_line(input logic [31:0] la);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = ref_word(la + 32'(i * 4));
      return l;
   endfunction

   // One complete CPU access, with latency, data, counter and memory-traffic checks
   task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input int n);
      logic [3:0]   idx;
      logic [22:0]  tag;
      logic [31:0]  waddr, vic_addr;
      logic [255:0] vic_line;
      logic [31:0]  got_data;
      logic         hit_exp, wb_exp;
      int           pos, stall_exp, stalls, txn_exp;
      line_t        nl;
      idx   = addr[8:5];
      tag   = addr[31:9];
      waddr = {addr[31:2], 2'b00};
      pos   = -1;
      for (int i = 0; i < resident[idx].size(); i++)
         if (resident[idx][i].tag == tag) pos = i;
      hit_exp  = (pos >= 0);
      wb_exp   = 1'b0;
      vic_addr = '0;
      if (!hit_exp && resident[idx].size() == 2 && resident[idx][0].dirty) begin
         wb_exp   = 1'b1;
         vic_addr = {resident[idx][0].tag, idx, 5'b0};
      end
      vic_line  = ref_line(vic_addr);
      stall_exp = hit_exp ? 0 : (wb_exp ? 2 * n + 4 : n + 3);
      txn_exp   = hit_exp ? 0 : (wb_exp ? 2 : 1);

      txn_log.delete();
      ack_delay = n;
      @(negedge clk_i);
      cpu_req_i  = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = addr;
      cpu_data_i = wdata;
      #1;
      stalls = 0;
      while (cpu_stall_o && stalls < 300) begin
         @(negedge clk_i);
         #1;
         stalls++;
      end
      checkOutput("stall_cycles", 256'(stalls), 256'(stall_exp));
      got_data = cpu_data_o;
      @(posedge clk_i);
      #1;
      cpu_req_i = 1'b0;
      cpu_we_i  = 1'b0;

      if (!hit_exp) begin
         ref_miss = sat_inc(ref_miss);
         if (resident[idx].size() == 2) void'(resident[idx].pop_front());
         nl.tag   = tag;
         nl.dirty = 1'b0;
         resident[idx].push_back(nl);
         pos = resident[idx].size() - 1;
      end
      ref_hit = sat_inc(ref_hit);
      if (we) begin
         ref_words[waddr]     = wdata;
         resident[idx][pos].dirty = 1'b1;
      end else begin
         checkOutput("load_data", 256'(got_data), 256'(ref_word(waddr)));
      end
      checkOutput("hit_cnt", 256'(hit_cnt_o), 256'(ref_hit));
      checkOutput("miss_cnt", 256'(miss_cnt_o), 256'(ref_miss));
      checkOutput("txn_count", 256'(txn_log.size()), 256'(txn_exp));
      if (txn_log.size() == txn_exp && txn_exp > 0) begin
         if (wb_exp) begin
            checkOutput("wb_write", 256'(txn_log[0].wr), 256'(1));
            checkOutput("wb_addr", 256'(txn_log[0].addr), 256'(vic_addr));
            checkOutput("wb_data", txn_log[0].data, vic_line);
         end
         checkOutput("fill_write", 256'(txn_log[txn_exp-1].wr), 256'(0));
         checkOutput("fill_addr", 256'(txn_log[txn_exp-1].addr), 256'({addr[31:5], 5'b0}));
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic found;
      rst_i      = 1'b1;
      cpu_req_i  = 1'b0;
      cpu_we_i   = 1'b0;
      cpu_addr_i = '0;
      cpu_data_i = '0;
      ref_words[32'h40] = 32'd6;
      ref_words[32'h44] = 32'd7;
      for (int i = 2; i < 8; i++) ref_words[32'h40 + 32'(i * 4)] = 32'd0;

      repeat (2) @(negedge clk_i);
      #1;
      checkOutput("rst_hit_cnt", 256'(hit_cnt_o), 256'(0));
      checkOutput("rst_miss_cnt", 256'(miss_cnt_o), 256'(0));
      checkOutput("rst_mem_en", 256'(mem_enable_o), 256'(0));
      checkOutput("rst_stall", 256'(cpu_stall_o), 256'(0));
      checkOutput("rst_cpu_data", 256'(cpu_data_o), 256'(0));
      rst_i = 1'b0;

      $display("[TB] first load miss with clean fill");
      applyStimulus(1'b0, 32'h0000_0040, 32'd0, 3);

      $display("[TB] store hit then load back");
      applyStimulus(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 3);
      checkOutput("store_tag", 256'(tag_mem[2][0]), 256'({1'b1, 1'b1, 23'd0}));
      checkOutput("store_word1", 256'(data_mem[2][0][63:32]), 256'(32'hDEAD_BEEF));
      applyStimulus(1'b0, 32'h0000_0044, 32'd0, 3);

      $display("[TB] dirty victim writeback");
      applyStimulus(1'b0, 32'h0000_0240, 32'd0, 3);
      applyStimulus(1'b1, 32'h0000_0048, 32'h1234_5678, 3);
      applyStimulus(1'b0, 32'h0000_0440, 32'd0, 3);

      $display("[TB] long ack delay and stray ack in idle");
      applyStimulus(1'b0, 32'h0000_0640, 32'd0, 21);
      @(negedge clk_i);
      extra_ack = 1'b1;
      @(negedge clk_i);
      extra_ack = 1'b0;
      #1;
      checkOutput("idle_ack_mem_en", 256'(mem_enable_o), 256'(0));
      checkOutput("idle_ack_stall", 256'(cpu_stall_o), 256'(0));
      applyStimulus(1'b0, 32'h0000_0644, 32'd0, 3);

      $display("[TB] reset during writeback");
      applyStimulus(1'b1, 32'h0000_0444, 32'hCAFE_F00D, 3);
      ack_delay = 50;
      @(negedge clk_i);
      cpu_req_i  = 1'b1;
      cpu_we_i   = 1'b0;
      cpu_addr_i = 32'h0000_0840;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk_i);
         #1;
         if (mem_enable_o && mem_write_o) found = 1'b1;
      end
      checkOutput("wb_entered", 256'(found), 256'(1));
      rst_i = 1'b1;
      #1;
      checkOutput("arst_mem_en", 256'(mem_enable_o), 256'(0));
      checkOutput("arst_mem_wr", 256'(mem_write_o), 256'(0));
      checkOutput("arst_mem_addr", 256'(mem_addr_o), 256'(0));
      checkOutput("arst_mem_data", mem_data_o, 256'(0));
      checkOutput("arst_cpu_data", 256'(cpu_data_o), 256'(0));
      checkOutput("arst_hit_cnt", 256'(hit_cnt_o), 256'(0));
      checkOutput("arst_miss_cnt", 256'(miss_cnt_o), 256'(0));
      cpu_req_i = 1'b0;
      #1;
      checkOutput("arst_stall", 256'(cpu_stall_o), 256'(0));
      @(negedge clk_i);
      rst_i    = 1'b0;
      ref_hit  = '0;
      ref_miss = '0;

      $display("[TB] randomized accesses");
      for (int k = 0; k < 60; k++) begin
         logic [31:0] a;
         a = {23'($urandom_range(0, 4)), 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
         applyStimulus(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 4));
      end

      $display("[TB] hit counter saturation");
      @(negedge clk_i);
      force dut.hit_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.hit_cnt_q;
      ref_hit = 32'hFFFF_FFFE;
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'h0000_0100, 32'd0, 2);
      checkOutput("hit_cnt_saturated", 256'(hit_cnt_o), 256'(32'hFFFF_FFFF));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
